draw_pixel_writer: RTL and testbench
====================================

Name: draw_pixel_writer

Overview:
- Consumer end of the draw-coordinate stream. Accepts the per-pixel x position, the drawing strobe and the done strobe from a line/span generator.
- Packs 4-bit pixels into 16-bit VRAM words with a per-nibble write mask, and issues masked VRAM write requests over a valid/ack handshake.
- Drives the generator's draw-enable as backpressure, so no pixel is lost while VRAM is busy.
- Sits between the blitter/draw generators and the VRAM arbiter.

Parameters:
- CORDW, 16, signed coordinate width; must match the generator.
- ADDRW, 16, VRAM word address width.

Ports:
- clk  in  1  clock.
- reset_i  in  1  asynchronous reset, active-high.
- base_addr_i  in  ADDRW  VRAM word address of pixel x=0 for the current span; held stable while busy_o.
- color_i  in  4  pixel color; sampled with each accepted pixel.
- drawing_i  in  1  generator presents a pixel at x_i this cycle.
- x_i  in  CORDW  signed pixel x coordinate.
- done_i  in  1  generator span-complete pulse.
- ena_draw_o  out  1  draw enable to the generator; a pixel is accepted when drawing_i && ena_draw_o.
- vram_sel_o  out  1  write request valid.
- vram_ack_i  in  1  arbiter accepts the request this cycle.
- vram_addr_o  out  ADDRW  write word address.
- vram_data_o  out  16  write data.
- vram_wr_mask_o  out  4  nibble write mask.
- busy_o  out  1  data held or flush in progress.
- done_o  out  1  all span writes acknowledged; high for one cycle.

Behaviour:
- Reset is asynchronous. All of the following clear immediately to 0: vram_sel_o, vram_addr_o, vram_data_o, vram_wr_mask_o, busy_o, done_o, and internal valid flags. FSM state goes to IDLE. ena_draw_o=1 after reset.
- Reset mid-operation drops any pending or held write silently.
- Pixel mapping:
  - word address = base_addr_i + (x_i >>> 2), arithmetic shift, truncated to ADDRW.
  - nibble n = x_i[1:0]; n=0 maps to data[15:12] and mask[3]; n=3 maps to data[3:0] and mask[0].
- Clipping: an accepted pixel with x_i < 0 is consumed and discarded; no state change.
- Two storage stages:
  - Accumulator: acc_valid, acc_addr, acc_data, acc_mask.
  - Output register: drives the vram_* ports; vram_sel_o = out_valid.
- Accepted pixel, acc empty: load acc with addr, data = color placed in nibble n (others 0), mask = one-hot n.
- Accepted pixel, same addr as acc: merge (OR the mask bit, replace nibble n). Repeating a nibble makes the last color win.
- Accepted pixel, different addr: acc moves to the output register and the new pixel loads acc, in the same cycle.
- Output register is free when !out_valid || vram_ack_i. The move and the ack may occur in the same cycle.
- ena_draw_o = (state != FLUSH) && (!acc_valid || !out_valid || vram_ack_i). This is combinational from state and vram_ack_i.
- Handshake: vram_addr_o/data/mask stay stable while vram_sel_o=1 && !vram_ack_i. A transfer completes on the clock edge with vram_ack_i=1. vram_ack_i while vram_sel_o=0 is ignored.
- FSM IDLE/ACTIVE:
  - IDLE to ACTIVE on the first accepted pixel with x_i >= 0.
  - done_i in IDLE (empty span, or all pixels clipped) pulses done_o the next cycle.
- FSM ACTIVE:
  - On done_i, go to FLUSH.
  - drawing_i and done_i in the same cycle: the pixel is processed first, then FLUSH.
- FSM FLUSH:
  - acc moves to the output register when the output register is free.
  - When acc is empty and out is empty (last ack edge), go to IDLE and pulse done_o for exactly one cycle.
- busy_o = acc_valid || out_valid || state==FLUSH (registered-equivalent).
- No flush on a full mask before address change or done. A word is written at most once per contiguous run.

Test Plan:
- base=0x1000, color=0xA, x=0..7, ack tied 1: two writes, (0x1000, 0xAAAA, mask 1111) then (0x1001, 0xAAAA, 1111). done_o pulses once, one cycle after the second ack edge.
- x=2..5, color=0xA: (0x1000, 0x00AA, 0011) then (0x1001, 0xAA00, 1100).
- Single pixel x=3, color=0x5: exactly one write, (0x1000, 0x0005, 0001).
- x=0..11, ack held low 10 cycles after first vram_sel_o:
  - ena_draw_o drops once acc holds word 0x1001 and out holds 0x1000.
  - vram_* stay stable while ack is low.
  - After ack resumes, all three words are written with no pixel lost or duplicated.
- x=-2..1, color=0xC: negative pixels are consumed but not written; one write, (0x1000, 0xCC00, 1100).
- Assert reset_i asynchronously mid-span with vram_sel_o=1: all outputs read 0 before the next clk edge. After release, a new x=0..3 span writes correctly.

Source files
------------

// File: rtl/draw_pixel_writer.sv
// Packs 4-bit pixels from a draw generator into masked 16-bit VRAM word writes,
// with an accumulator and output stage and backpressure to the generator.
module draw_pixel_writer #(
  parameter int CORDW = 16,
  parameter int ADDRW = 16
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [ADDRW-1:0] base_addr_i,
  input  logic [3:0]       color_i,
  input  logic             drawing_i,
  input  logic [CORDW-1:0] x_i,
  input  logic             done_i,
  output logic             ena_draw_o,
  output logic             vram_sel_o,
  input  logic             vram_ack_i,
  output logic [ADDRW-1:0] vram_addr_o,
  output logic [15:0]      vram_data_o,
  output logic [3:0]       vram_wr_mask_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t           state_reg, state_next;
  logic             acc_valid_reg, acc_valid_next;
  logic [ADDRW-1:0] acc_addr_reg, acc_addr_next;
  logic [15:0]      acc_data_reg, acc_data_next;
  logic [3:0]       acc_mask_reg, acc_mask_next;
  logic             out_valid_reg, out_valid_next;
  logic [ADDRW-1:0] out_addr_reg, out_addr_next;
  logic [15:0]      out_data_reg, out_data_next;
  logic [3:0]       out_mask_reg, out_mask_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;

  logic signed [CORDW-1:0] x_shift;
  logic [ADDRW-1:0]        pix_addr;
  logic [3:0]              pix_mask;
  logic [15:0]             pix_data;
  logic [15:0]             pix_bits;
  logic                    out_free;
  logic                    pix_ok;

  assign x_shift  = $signed(x_i) >>> 2;
  assign pix_addr = base_addr_i + ADDRW'(x_shift);

  // Nibble 0 is the most significant nibble of the word and mask bit 3.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    assign pix_mask[3-gi]          = (x_i[1:0] == 2'(gi));
    assign pix_bits[15-4*gi -: 4]  = {4{pix_mask[3-gi]}};
    assign pix_data[15-4*gi -: 4]  = pix_mask[3-gi] ? color_i : 4'h0;
  end

  assign out_free   = !out_valid_reg || vram_ack_i;
  assign ena_draw_o = (state_reg != FLUSH) && (!acc_valid_reg || out_free);
  // Negative x is accepted from the generator but never stored.
  assign pix_ok     = drawing_i && ena_draw_o && !x_i[CORDW-1];

  always_comb begin
    state_next     = state_reg;
    acc_valid_next = acc_valid_reg;
    acc_addr_next  = acc_addr_reg;
    acc_data_next  = acc_data_reg;
    acc_mask_next  = acc_mask_reg;
    out_valid_next = out_valid_reg;
    out_addr_next  = out_addr_reg;
    out_data_next  = out_data_reg;
    out_mask_next  = out_mask_reg;
    done_next      = 1'b0;

    if (out_valid_reg && vram_ack_i) out_valid_next = 1'b0;

    if (pix_ok) begin
      if (acc_valid_reg && pix_addr == acc_addr_reg) begin
        acc_data_next = (acc_data_reg & ~pix_bits) | pix_data;
        acc_mask_next = acc_mask_reg | pix_mask;
      end else begin
        if (acc_valid_reg) begin
          out_valid_next = 1'b1;
          out_addr_next  = acc_addr_reg;
          out_data_next  = acc_data_reg;
          out_mask_next  = acc_mask_reg;
        end
        acc_valid_next = 1'b1;
        acc_addr_next  = pix_addr;
        acc_data_next  = pix_data;
        acc_mask_next  = pix_mask;
      end
    end

    case (state_reg)
      IDLE: begin
        if (pix_ok)      state_next = done_i ? FLUSH : ACTIVE;
        else if (done_i) done_next  = 1'b1;
      end
      ACTIVE: begin
        if (done_i) state_next = FLUSH;
      end
      FLUSH: begin
        if (acc_valid_reg && out_free) begin
          out_valid_next = 1'b1;
          out_addr_next  = acc_addr_reg;
          out_data_next  = acc_data_reg;
          out_mask_next  = acc_mask_reg;
          acc_valid_next = 1'b0;
        end
        if (!acc_valid_next && !out_valid_next) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = acc_valid_next || out_valid_next || (state_next == FLUSH);
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      acc_valid_reg <= 1'b0;
      acc_addr_reg  <= '0;
      acc_data_reg  <= '0;
      acc_mask_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      out_mask_reg  <= '0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_valid_reg <= acc_valid_next;
      acc_addr_reg  <= acc_addr_next;
      acc_data_reg  <= acc_data_next;
      acc_mask_reg  <= acc_mask_next;
      out_valid_reg <= out_valid_next;
      out_addr_reg  <= out_addr_next;
      out_data_reg  <= out_data_next;
      out_mask_reg  <= out_mask_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
    end
  end

  assign vram_sel_o     = out_valid_reg;
  assign vram_addr_o    = out_addr_reg;
  assign vram_data_o    = out_data_reg;
  assign vram_wr_mask_o = out_mask_reg;
  assign busy_o         = busy_reg;
  assign done_o         = done_reg;

endmodule

// File: tb/tb_draw_pixel_writer.sv
// Randomized bench for draw_pixel_writer: spans are driven through the
// generator handshake and the observed VRAM writes are compared to a word map.
module tb_draw_pixel_writer;

  localparam int CORDW = 16;
  localparam int ADDRW = 16;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic [ADDRW-1:0] base_addr_i = '0;
  logic [3:0]       color_i = '0;
  logic             drawing_i = 1'b0;
  logic [CORDW-1:0] x_i = '0;
  logic             done_i = 1'b0;
  logic             ena_draw_o;
  logic             vram_sel_o;
  logic             vram_ack_i = 1'b0;
  logic [ADDRW-1:0] vram_addr_o;
  logic [15:0]      vram_data_o;
  logic [3:0]       vram_wr_mask_o;
  logic             busy_o;
  logic             done_o;

  draw_pixel_writer #(.CORDW(CORDW), .ADDRW(ADDRW)) dut (
    .clk(clk), .reset_i(reset_i), .base_addr_i(base_addr_i), .color_i(color_i),
    .drawing_i(drawing_i), .x_i(x_i), .done_i(done_i), .ena_draw_o(ena_draw_o),
    .vram_sel_o(vram_sel_o), .vram_ack_i(vram_ack_i), .vram_addr_o(vram_addr_o),
    .vram_data_o(vram_data_o), .vram_wr_mask_o(vram_wr_mask_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Acknowledge behaviour: 0 always, 1 random, 2 low for 10 sel cycles, 3 never.
  int ack_mode = 0;
  int sel_seen = 0;
  always @(negedge clk) begin
    case (ack_mode)
      0: vram_ack_i = 1'b1;
      1: vram_ack_i = ($urandom_range(0, 2) != 0);
      2: begin
        if (vram_sel_o) sel_seen++;
        vram_ack_i = (sel_seen > 10);
      end
      default: vram_ack_i = 1'b0;
    endcase
  end

  typedef struct packed {logic [15:0] a; logic [15:0] d; logic [3:0] m;} wr_t;
  wr_t  obs[$];
  int   last_xfer = -1;
  int   done_cnt = 0;
  int   done_cyc = -1;
  bit   held = 0;
  wr_t  held_val;

  always @(negedge clk) begin
    #3;
    if (reset_i) begin
      held = 0;
    end else begin
      if (held) check("hold_stable", {vram_sel_o, vram_addr_o, vram_data_o, vram_wr_mask_o},
                      {1'b1, held_val});
      if (vram_sel_o && vram_ack_i) begin
        obs.push_back('{vram_addr_o, vram_data_o, vram_wr_mask_o});
        last_xfer = cyc;
      end
      held = vram_sel_o && !vram_ack_i;
      held_val = '{vram_addr_o, vram_data_o, vram_wr_mask_o};
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Drives one span and checks writes, done count and done timing against a word map.
  task automatic run_span(input logic [15:0] base, input int x0, input int n, input int dir,
                          input logic [3:0] col, input bit rand_col, input bit done_with_last,
                          input int ack_md, output int stalls);
    int xs[$];
    logic [3:0] cols[$];
    logic [15:0] ed[int];
    logic [3:0] em[int];
    int ord[$];
    int done_sent;
    int guard;
    logic [15:0] td;
    logic [3:0] tm;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      xs.push_back(x0 + i * dir);
      cols.push_back(rand_col ? 4'($urandom_range(0, 15)) : col);
    end
    for (int i = 0; i < n; i++) begin
      int w, nib;
      if (xs[i] < 0) continue;
      w = xs[i] / 4;
      nib = xs[i] % 4;
      if (!ed.exists(w)) begin
        ed[w] = 16'h0; em[w] = 4'h0; ord.push_back(w);
      end
      td = ed[w]; td[15 - 4 * nib -: 4] = cols[i]; ed[w] = td;
      tm = em[w]; tm[3 - nib] = 1'b1; em[w] = tm;
    end

    @(negedge clk);
    obs.delete();
    done_cnt = 0; done_cyc = -1; last_xfer = -1; done_sent = -1;
    ack_mode = ack_md; sel_seen = 0;
    base_addr_i = base;
    for (int i = 0; i < n; i++) begin
      drawing_i = 1'b1; x_i = CORDW'(xs[i]); color_i = cols[i]; done_i = 1'b0;
      #2;
      guard = 0;
      while (!ena_draw_o && guard < 200) begin
        stalls++; guard++;
        @(negedge clk); #2;
      end
      if (guard >= 200) begin
        check("ena_timeout", 0, 1);
        break;
      end
      if (i == n - 1 && done_with_last) begin
        done_i = 1'b1; done_sent = cyc;
      end
      @(negedge clk);
    end
    drawing_i = 1'b0;
    if (!done_with_last) begin
      done_i = 1'b1; done_sent = cyc;
      @(negedge clk);
    end
    done_i = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 300) begin
      @(negedge clk); guard++;
    end
    repeat (5) @(negedge clk);
    #4;
    check("done_count", done_cnt, 1);
    check("write_count", obs.size(), ord.size());
    for (int i = 0; i < ord.size() && i < obs.size(); i++)
      check($sformatf("write%0d", i), obs[i], {16'(base + ord[i]), ed[ord[i]], em[ord[i]]});
    if (ord.size() > 0) check("done_timing", done_cyc, last_xfer + 1);
    else                check("done_timing_idle", done_cyc, done_sent + 1);
    check("busy_idle", busy_o, 1'b0);
    $display("span base=%h x0=%0d n=%0d dir=%0d ack=%0d writes=%0d stalls=%0d",
             base, x0, n, dir, ack_md, obs.size(), stalls);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_sel"},  vram_sel_o, 1'b0);
    check({tag, "_addr"}, vram_addr_o, '0);
    check({tag, "_data"}, vram_data_o, '0);
    check({tag, "_mask"}, vram_wr_mask_o, '0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_ena"},  ena_draw_o, 1'b1);
  endtask

  initial begin
    int st;
    #1;
    check_zero_outputs("rst");
    repeat (3) @(negedge clk);
    reset_i = 1'b0;

    run_span(16'h1000, 0, 8, 1, 4'hA, 0, 0, 0, st);
    check("t1_w0", obs.size() > 0 ? obs[0] : '0, {16'h1000, 16'hAAAA, 4'hF});
    run_span(16'h1000, 2, 4, 1, 4'hA, 0, 0, 0, st);
    check("t2_w1", obs.size() > 1 ? obs[1] : '0, {16'h1001, 16'hAA00, 4'hC});
    run_span(16'h1000, 3, 1, 1, 4'h5, 0, 0, 0, st);
    check("t3_w0", obs.size() > 0 ? obs[0] : '0, {16'h1000, 16'h0005, 4'h1});
    run_span(16'h1000, 0, 12, 1, 4'h0, 1, 0, 2, st);
    check("t4_stalled", st > 0, 1'b1);
    run_span(16'h1000, -2, 4, 1, 4'hC, 0, 0, 0, st);
    check("t5_w0", obs.size() > 0 ? obs[0] : '0, {16'h1000, 16'hCC00, 4'hC});
    run_span(16'h2000, -7, 5, 1, 4'h0, 1, 1, 1, st);

    // Asynchronous reset while a write is pending.
    @(negedge clk);
    ack_mode = 3;
    base_addr_i = 16'h1000;
    for (int i = 0; i < 5; i++) begin
      drawing_i = 1'b1; x_i = CORDW'(i); color_i = 4'h7;
      @(negedge clk);
    end
    drawing_i = 1'b0;
    #2;
    check("pre_rst_sel", vram_sel_o, 1'b1);
    reset_i = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    @(negedge clk);
    reset_i = 1'b0;
    run_span(16'h1000, 0, 4, 1, 4'h0, 1, 0, 0, st);

    for (int k = 0; k < 25; k++)
      run_span(16'($urandom), $urandom_range(0, 32) - 8, $urandom_range(1, 16),
               ($urandom_range(0, 1) != 0) ? 1 : -1, 4'h0, 1, bit'($urandom_range(0, 1)),
               $urandom_range(0, 1), st);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
